// File: rtl/modulo_05_pkg.sv
// Shared types and constants for the modulo_05 7-segment display stage.
package modulo_05_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } disp_state_t;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_SINGLE = 2'd1,
        ST_DOUBLE = 2'd2
    } status_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Status code: a double error outranks any reported position.
    function automatic status_t status_of(input logic dbl, input logic [3:0] pos);
        status_t st;
        if (dbl) begin
            st = ST_DOUBLE;
        end else if (pos != 4'd0) begin
            st = ST_SINGLE;
        end else begin
            st = ST_OK;
        end
        return st;
    endfunction

endpackage

// File: rtl/modulo_05_hex_to_7seg.sv
// Combinational hex-digit font, active-low segments {g,f,e,d,c,b,a}.
module hex_to_7seg
    import modulo_05_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    // Font lookup for the sixteen hex glyphs.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_value)
            4'h0:    o_seg = 7'b1000000;
            4'h1:    o_seg = 7'b1111001;
            4'h2:    o_seg = 7'b0100100;
            4'h3:    o_seg = 7'b0110000;
            4'h4:    o_seg = 7'b0011001;
            4'h5:    o_seg = 7'b0010010;
            4'h6:    o_seg = 7'b0000010;
            4'h7:    o_seg = 7'b1111000;
            4'h8:    o_seg = 7'b0000000;
            4'h9:    o_seg = 7'b0010000;
            4'hA:    o_seg = 7'b0001000;
            4'hB:    o_seg = 7'b0000011;
            4'hC:    o_seg = 7'b1000110;
            4'hD:    o_seg = 7'b0100001;
            4'hE:    o_seg = 7'b0000110;
            4'hF:    o_seg = 7'b0001110;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/modulo_05.sv
// Display stage after SECDED correction: captures word, double-error flag and
// error position on load and scans them onto a 4-digit common-anode display
// with a one-cycle blank between digits.
// Optional feature macro: MODULO_05_BLINK_EN (blink display on double error).
module modulo_05
    import modulo_05_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter int BLINK_DIV   = 6750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] w_corregida_b4,
    input  logic [3:0] pos_error,
    output logic [3:0] anodo,
    output logic [6:0] segmentos
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    // Dividers below 2 leave no room for a lit period or a blink phase.
    if ((REFRESH_DIV < 2) || (BLINK_DIV < 2)) begin : g_param_check
        $error("modulo_05: REFRESH_DIV and BLINK_DIV must be at least 2");
    end

    logic [3:0]    r_data;
    logic          r_dbl;
    logic [3:0]    r_pos;
    disp_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    disp_state_t   w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_idx_nxt;
    status_t       w_status;
    logic [3:0]    w_hex;
    logic [6:0]    w_font;
    logic [6:0]    w_glyph;
    logic          w_blink_off;

    // Capture registers; reset wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 4'd0;
            r_dbl  <= 1'b0;
            r_pos  <= 4'd0;
        end else if (load) begin
            r_data <= w_corregida_b4[3:0];
            r_dbl  <= w_corregida_b4[4];
            r_pos  <= pos_error;
        end else begin
            r_data <= r_data;
            r_dbl  <= r_dbl;
            r_pos  <= r_pos;
        end
    end

    // Scan state, refresh counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: one blank cycle, then REFRESH_DIV lit cycles per digit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            BLANK: begin
                w_state_nxt = SHOW;
            end
            SHOW: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = BLANK;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // Select the value shown on the active digit.
    always_comb begin
        w_status = status_of(r_dbl, r_pos);
        w_hex    = 4'd0;
        case (r_idx)
            2'd0:    w_hex = r_data;
            2'd1:    w_hex = r_pos;
            2'd2:    w_hex = {2'b00, w_status};
            default: w_hex = 4'd0;
        endcase
    end

    hex_to_7seg u_font (
        .i_value (w_hex),
        .o_seg   (w_font)
    );

    // Leftmost digit is a fixed 'E' marker or blank rather than a hex value.
    always_comb begin
        w_glyph = w_font;
        if (r_idx == 2'd3) begin
            w_glyph = r_dbl ? SEG_E : SEG_BLANK;
        end else begin
            w_glyph = w_font;
        end
    end

`ifdef MODULO_05_BLINK_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_off;

    // Free-running blink timebase; phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + {{(BW-1){1'b0}}, 1'b1};
            r_blink_off <= r_blink_off;
        end
    end

    assign w_blink_off = r_blink_off;
`else
    assign w_blink_off = 1'b0;
`endif

    // Registered display drivers; all digits dark during BLANK.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodo     <= 4'b1111;
            segmentos <= SEG_BLANK;
        end else if (r_state == SHOW) begin
            if (r_dbl && w_blink_off) begin
                anodo <= 4'b1111;
            end else begin
                anodo <= ~(4'b0001 << r_idx);
            end
            segmentos <= w_glyph;
        end else begin
            anodo     <= 4'b1111;
            segmentos <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_modulo_05.sv
// Directed testbench for modulo_05 with REFRESH_DIV = 4, BLINK_DIV = 8.
module tb_modulo_05;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] w_in;
    logic [3:0] pos_in;
    logic [3:0] anodo;
    logic [6:0] segmentos;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modulo_05 #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .w_corregida_b4 (w_in),
        .pos_error      (pos_in),
        .anodo          (anodo),
        .segmentos      (segmentos)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for digit d to be lit, then check its glyph.
    task automatic expect_digit(input int d, input logic [6:0] exp_seg, input string tag);
        logic [3:0] an_exp;
        bit         found;
        an_exp = 4'b1111 ^ (4'b0001 << d);
        found  = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (anodo == an_exp) found = 1'b1;
        end
        if (found) chk(tag, {9'd0, segmentos}, {9'd0, exp_seg});
        else       chk({tag, "_timeout"}, 16'd0, 16'd1);
    endtask

    task automatic do_load(input logic [4:0] wv, input logic [3:0] pv);
        @(negedge clk);
        w_in = wv; pos_in = pv; load = 1'b1;
        @(negedge clk);
        load = 1'b0; w_in = 5'd0; pos_in = 4'd0;
        @(negedge clk);
    endtask

`ifdef MODULO_05_BLINK_EN
    task automatic max_dark_run(input int cycles, output int run_max);
        int run;
        run = 0; run_max = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (anodo == 4'b1111) run++;
            else run = 0;
            if (run > run_max) run_max = run;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        int         run_max;
        rst = 1'b1; load = 1'b0; w_in = 5'd0; pos_in = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_anodo", {12'd0, anodo}, 16'h000F);
        chk("rst_seg", {9'd0, segmentos}, 16'h007F);
        rst = 1'b0;

        // Scan order after reset: blank, 4 lit cycles per digit, 1110->0111 and wrap.
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if ((k % 5) == 0) begin
                an_exp  = 4'b1111;
                seg_exp = 7'b1111111;
            end else begin
                an_exp  = 4'b1111 ^ (4'b0001 << ((k / 5) % 4));
                seg_exp = (((k / 5) % 4) == 3) ? 7'b1111111 : 7'b1000000;
            end
            chk($sformatf("scan_an_%0d", k), {12'd0, anodo}, {12'd0, an_exp});
            chk($sformatf("scan_seg_%0d", k), {9'd0, segmentos}, {9'd0, seg_exp});
        end

        do_load(5'b01010, 4'b0000);
        expect_digit(0, 7'b0001000, "t1_d0_A");
        expect_digit(1, 7'b1000000, "t1_d1_0");
        expect_digit(2, 7'b1000000, "t1_d2_0");
        expect_digit(3, 7'b1111111, "t1_d3_blank");

        do_load(5'b00011, 4'b0101);
        expect_digit(0, 7'b0110000, "t2_d0_3");
        expect_digit(1, 7'b0010010, "t2_d1_5");
        expect_digit(2, 7'b1111001, "t2_d2_1");
        expect_digit(3, 7'b1111111, "t2_d3_blank");
`ifdef MODULO_05_BLINK_EN
        max_dark_run(64, run_max);
        chk("blink_single_run", run_max[15:0], 16'd1);
`endif

        do_load(5'b10000, 4'b0110);
        expect_digit(0, 7'b1000000, "t3_d0_0");
        expect_digit(1, 7'b0000010, "t3_d1_6");
        expect_digit(2, 7'b0100100, "t3_d2_2");
        expect_digit(3, 7'b0000110, "t3_d3_E");
`ifdef MODULO_05_BLINK_EN
        max_dark_run(64, run_max);
        chk("blink_double_run", (run_max >= 8) ? 16'd1 : 16'd0, 16'd1);
`endif

        // Reset and load together: reset must win.
        @(negedge clk);
        rst = 1'b1; load = 1'b1; w_in = 5'b01111; pos_in = 4'b1010;
        @(negedge clk);
        chk("rstld_anodo", {12'd0, anodo}, 16'h000F);
        chk("rstld_seg", {9'd0, segmentos}, 16'h007F);
        rst = 1'b0; load = 1'b0; w_in = 5'd0; pos_in = 4'd0;
        expect_digit(0, 7'b1000000, "t4_d0_0");
        expect_digit(1, 7'b1000000, "t4_d1_0");
        expect_digit(2, 7'b1000000, "t4_d2_0");
        expect_digit(3, 7'b1111111, "t4_d3_blank");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
